// File: rtl/ysyx_220053_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on the request and result sides.
module ysyx_220053_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [XLEN-1:0] hi, lo, opnd;
  logic [CW-1:0]   count;
  logic [3:0]      op_r;
  logic            special_r, neg_prod, neg_rem;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready && !flush;
  // a result transfers with out_valid && out_ready. in_ready is only high in IDLE.
  logic accept;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Operand preparation at acceptance
  logic            is_w, is_div, is_rsv, a_signed, b_signed, sa, sb;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_lo_sext, mag_a, mag_b, min_val, special_val;

  assign is_w     = op[3];
  assign is_div   = op[2];
  assign is_rsv   = (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
  assign a_signed = is_div ? ~op[0] : (op != 4'd3);
  assign b_signed = is_div ? ~op[0] : ~op[1];
  assign a_lo_sext = {{HALF{src_a[HALF-1]}}, src_a[HALF-1:0]};

  always_comb begin
    a_ext = src_a;
    b_ext = src_b;
    if (is_w) begin
      a_ext = op[0] ? {{HALF{1'b0}}, src_a[HALF-1:0]} : {{HALF{src_a[HALF-1]}}, src_a[HALF-1:0]};
      b_ext = op[0] ? {{HALF{1'b0}}, src_b[HALF-1:0]} : {{HALF{src_b[HALF-1]}}, src_b[HALF-1:0]};
    end
  end

  assign sa      = a_signed & a_ext[XLEN-1];
  assign sb      = b_signed & b_ext[XLEN-1];
  assign mag_a   = sa ? (~a_ext + 1'b1) : a_ext;
  assign mag_b   = sb ? (~b_ext + 1'b1) : b_ext;
  // Most negative value of the operation width, already sign-extended for W ops
  assign min_val = is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = is_div && (b_ext == '0);
  assign ovf      = is_div && !op[0] && (b_ext == '1) && (a_ext == min_val);
  assign special  = is_rsv || div_zero || ovf;

  always_comb begin
    special_val = '0;
    if (div_zero)  special_val = op[1] ? (is_w ? a_lo_sext : a_ext) : '1;
    else if (ovf)  special_val = op[1] ? '0 : a_ext;
  end

  // One iteration: multiply shifts the product {hi,lo} right, divide shifts {hi,lo} left
  logic [XLEN:0]   sum, shifted, diff;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (op_r[2]) begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection once all iterations are done
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, div_sel, final_val;

  always_comb begin
    prod_s  = neg_prod ? (~{hi, lo} + 1'b1) : {hi, lo};
    quo_s   = neg_prod ? (~lo + 1'b1) : lo;
    rem_s   = neg_rem  ? (~hi + 1'b1) : hi;
    div_sel = op_r[1] ? rem_s : quo_s;
    if (op_r[2])
      final_val = op_r[3] ? {{HALF{div_sel[HALF-1]}}, div_sel[HALF-1:0]} : div_sel;
    else if (op_r[3])
      final_val = {{HALF{prod_s[HALF-1]}}, prod_s[HALF-1:0]};
    else if (op_r == 4'd0)
      final_val = prod_s[XLEN-1:0];
    else
      final_val = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = CALC;
      CALC: if (special_r || count == CW'(XLEN)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      count     <= '0;
      op_r      <= '0;
      special_r <= 1'b0;
      neg_prod  <= 1'b0;
      neg_rem   <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      op_r      <= op;
      special_r <= special;
      neg_prod  <= sa ^ sb;
      neg_rem   <= sa;
      count     <= '0;
      hi        <= '0;
      // Special results park in lo and are published one cycle later
      if (special) begin
        lo   <= special_val;
        opnd <= '0;
      end else if (is_div) begin
        lo   <= mag_a;
        opnd <= mag_b;
      end else begin
        lo   <= mag_b;
        opnd <= mag_a;
      end
    end else if (state == CALC && !flush) begin
      if (special_r) begin
        result <= lo;
      end else if (count == CW'(XLEN)) begin
        result <= final_val;
      end else begin
        hi    <= hi_n;
        lo    <= lo_n;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_220053_muldiv.sv
// Bench for ysyx_220053_muldiv: directed and random ops against an arithmetic reference model.
module tb_ysyx_220053_muldiv;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]      op;
  logic [XLEN-1:0] src_a, src_b, result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  ysyx_220053_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit is_special(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o >= 4'd9 && o <= 4'd11) return 1'b1;
    if (o >= 4'd4 && o <= 4'd7)
      return (b == 0) || ((o == 4'd4 || o == 4'd6) && a == MIN64 && b == '1);
    if (o >= 4'd12)
      return (b[31:0] == 0) ||
             ((o == 4'd12 || o == 4'd14) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return 1'b0;
  endfunction

  // Reference model: RISC-V M semantics from plain wide arithmetic
  function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0]  sa64, sb64;
    logic signed [31:0]  a32, b32;
    logic [31:0]         ua32, ub32, m32;
    logic [63:0]         m64;
    sa64 = a; sb64 = b;
    a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    case (o)
      4'd0: begin m64 = a * b; return m64; end
      4'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
      4'd2: begin pa = {{64{a[63]}}, a}; pb = {64'b0, b}; p = pa * pb; return p[127:64]; end
      4'd3: begin pa = {64'b0, a}; pb = {64'b0, b}; p = pa * pb; return p[127:64]; end
      4'd4: begin
        if (b == 0) return '1;
        if (a == MIN64 && b == '1) return a;
        return sa64 / sb64;
      end
      4'd5: return (b == 0) ? '1 : a / b;
      4'd6: begin
        if (b == 0) return a;
        if (a == MIN64 && b == '1) return 64'd0;
        return sa64 % sb64;
      end
      4'd7: return (b == 0) ? a : a % b;
      4'd8: begin m32 = ua32 * ub32; return sext32(m32); end
      4'd12: begin
        if (b32 == 0) return '1;
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return sext32(a32);
        return sext32(a32 / b32);
      end
      4'd13: return (ub32 == 0) ? '1 : sext32(ua32 / ub32);
      4'd14: begin
        if (b32 == 0) return sext32(a32);
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return 64'd0;
        return sext32(a32 % b32);
      end
      4'd15: return (ub32 == 0) ? sext32(ua32) : sext32(ua32 % ub32);
      default: return 64'd0;
    endcase
  endfunction

  // driver tasks
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain", {63'b0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input int stall);
    int lat;
    int exp_lat;
    logic [63:0] exp_v;
    exp_q.push_back(ref_model(o, a, b));
    exp_lat = is_special(o, a, b) ? 1 : XLEN + 1;
    @(negedge clk);
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    src_a = {$urandom, $urandom};
    src_b = {$urandom, $urandom};
    check("accept_in_ready", {63'b0, in_ready}, 64'd0);
    check("accept_busy", {63'b0, busy}, 64'd1);
    wait_valid(lat);
    check($sformatf("latency_op%0d", o), 64'(lat), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    check($sformatf("result_op%0d", o), result, exp_v);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'b0, out_valid}, 64'd1);
      check("stall_result", result, exp_v);
    end
    drain();
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return MIN64;
      4: return {$urandom, 32'h8000_0000};
      5: return {32'h0, 32'hFFFF_FFFF};
      6: return 64'($urandom_range(0, 100)) * ($urandom_range(0, 1) ? 64'd1 : '1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lat;
    logic any_valid;
    logic [63:0] ra, rb;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // directed cases
    run_op(4'd0, 64'd7, -64'sd3, 10);
    run_op(4'd1, MIN64, 64'd2, 0);
    run_op(4'd3, MIN64, 64'd2, 0);
    run_op(4'd2, '1, '1, 0);
    run_op(4'd4, -64'sd7, 64'd2, 0);
    run_op(4'd6, -64'sd7, 64'd2, 0);
    run_op(4'd5, 64'd100, 64'd7, 0);
    run_op(4'd7, 64'd100, 64'd7, 0);
    run_op(4'd4, 64'd5, 64'd0, 0);
    run_op(4'd6, 64'd5, 64'd0, 0);
    run_op(4'd4, MIN64, '1, 0);
    run_op(4'd14, 64'h8000_0000, '1, 0);
    run_op(4'd8, 64'h7FFF_FFFF, 64'd2, 0);
    run_op(4'd13, '1, 64'd2, 0);
    run_op(4'd10, 64'd123, 64'd456, 0);

    // result handshake coinciding with a new request: taken only from IDLE
    @(negedge clk);
    in_valid = 1'b1; op = 4'd5; src_a = 64'd100; src_b = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_first", result, 64'd14);
    in_valid = 1'b1; op = 4'd7; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_not_taken", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_taken", {63'b0, busy}, 64'd1);
    wait_valid(lat);
    check("b2b_latency", 64'(lat), 64'(XLEN + 1));
    check("b2b_second", result, 64'd2);
    drain();

    // flush mid-CALC; a request alongside the flush is dropped
    @(negedge clk);
    in_valid = 1'b1; op = 4'd4; src_a = 64'd1000; src_b = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 4'd5; src_a = 64'd9; src_b = 64'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    any_valid = 1'b0;
    repeat (XLEN + 5) begin
      @(posedge clk); #1;
      any_valid |= out_valid | busy;
    end
    check("flush_quiet", {63'b0, any_valid}, 64'd0);
    run_op(4'd5, 64'd9, 64'd3, 0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; src_a = 64'd11; src_b = 64'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'b0, out_valid}, 64'd0);
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_in_ready", {63'b0, in_ready}, 64'd1);
    check("arst_result", result, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // random ops, reserved codes included
    for (int n = 0; n < 120; n++) begin
      ra = rand_opnd();
      rb = rand_opnd();
      run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_220053_muldiv.md
Name: ysyx_220053_muldiv

Overview:
Iterative RV64M multiply/divide unit, parametrised in XLEN. It sits beside the combinational ALU in the EX stage and handles MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU and the W variants. Operands and results move over a valid/ready handshake on each side. Computation is one bit per cycle with fixed latency, and the EX stage stalls on in_ready/out_valid.

Parameters:
XLEN, 64, datapath width; W ops act on the low XLEN/2 bits; must be even and >= 8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of any in-flight or completed op
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; 9-11 reserved
src_a  in  XLEN  rs1 / dividend / multiplicand
src_b  in  XLEN  rs2 / divisor / multiplier
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  XLEN  result, held stable while out_valid=1 and out_ready=0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, result=0, busy=0, in_ready=1, all internal registers cleared. Reset mid-operation abandons the op with no output.
- States:
  - IDLE: in_ready=1. A request is accepted when in_valid&&in_ready at a rising edge; op and operands are latched.
  - Accepted op is special or reserved: go to DONE next cycle.
  - Accepted op is normal: go to CALC with count=0.
  - CALC: one iteration per cycle; after XLEN iterations go to DONE.
  - DONE: out_valid=1; on out_ready go to IDLE. in_ready=0 in CALC and DONE, so there is no back-to-back acceptance.
- Latency: acceptance at edge E0 gives out_valid at E0+XLEN+1 for normal ops and at E0+1 for special or reserved ops.
- Operand preparation:
  - W ops: operands are the low XLEN/2 bits, sign-extended (MULW, DIVW, REMW) or zero-extended (DIVUW, REMUW) to XLEN.
  - Signed operands are converted to magnitudes and their signs recorded.
  - MULHSU treats src_a as signed and src_b as unsigned.
- Multiply: shift-add over 2*XLEN product bits.
  - Product is negated at the end if the sign bits differ.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
  - MULW returns the low XLEN/2 bits of the product, sign-extended.
- Divide: restoring division of magnitudes over XLEN iterations.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - W ops return the low XLEN/2 bits of the result, sign-extended to XLEN.
- Special cases, evaluated on the (extended) operands at acceptance, with 1-cycle latency:
  - Divisor==0: quotient=all ones, remainder=dividend. For W ops both are sign-extended from the low half.
  - Signed overflow (dividend=most negative value of the operation width, divisor=-1): quotient=dividend, remainder=0.
  - Reserved ops 9-11: result=0.
- flush has priority over everything: the next state is IDLE and out_valid drops at the next edge. A request presented in the same cycle as flush is not accepted.
- out_valid&&out_ready together with in_valid: the new request is not accepted that cycle; it is accepted next cycle, from IDLE.
- Operand inputs are ignored except at acceptance; result updates only on entry to DONE.

Test Plan:
- Reset then MUL, src_a=7, src_b=-3 -> out_valid exactly 65 cycles after acceptance, result=0xFFFFFFFFFFFFFFEB; in_ready=0 and busy=1 during the op.
- MULH a=0x8000000000000000, b=2 -> 0xFFFFFFFFFFFFFFFF; MULHU same operands -> 0x1; MULHSU a=-1, b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFFFFFFFFFD; REM -7/2 -> 0xFFFFFFFFFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV by 0 with a=5 -> result all ones, out_valid 1 cycle after acceptance; REM 5/0 -> 5; DIV 0x8000000000000000/-1 -> 0x8000000000000000; REMW 0x80000000/-1 -> 0.
- MULW a=0x7FFFFFFF, b=2 -> 0xFFFFFFFFFFFFFFFE; DIVUW a=0xFFFFFFFF_FFFFFFFF, b=2 -> 0x000000007FFFFFFF... high half ignored: low 0xFFFFFFFF/2=0x7FFFFFFF -> 0x000000007FFFFFFF.
- Back-pressure and kill:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, out_valid held.
  - flush in CALC at iteration 20 -> IDLE next cycle, no out_valid; then DIVU 9/3 -> 3.
  - rst_n low mid-CALC -> outputs at reset values immediately.
